// File: rtl/link_self_test_if.sv
// rtl/link_self_test_if.sv - control, status and serial-link bundle for link_self_test (LINK_ERR_INJECT_EN adds err_inject)
interface link_self_test_if #(
  parameter int NUM_WORDS = 16
);
  localparam int WC_W = $clog2(NUM_WORDS + 1);

  logic            f_layer;
  logic            start;
  logic            data_in;
  logic            data_out;
  logic            busy;
  logic            test_done;
  logic            test_pass;
  logic            timeout;
  logic [7:0]      err_cnt;
  logic [WC_W-1:0] word_cnt;
`ifdef LINK_ERR_INJECT_EN
  logic            err_inject;
`endif

  // Controller / test environment side
  modport master (
`ifdef LINK_ERR_INJECT_EN
    output err_inject,
`endif
    output f_layer, start, data_in,
    input  data_out, busy, test_done, test_pass, timeout, err_cnt, word_cnt
  );

  // Self-test block side
  modport slave (
`ifdef LINK_ERR_INJECT_EN
    input  err_inject,
`endif
    input  f_layer, start, data_in,
    output data_out, busy, test_done, test_pass, timeout, err_cnt, word_cnt
  );
endinterface

// File: rtl/link_self_test.sv
// rtl/link_self_test.sv - stacked-layer link pattern source / sync hunter / word checker (optional LINK_ERR_INJECT_EN)
module link_self_test #(
  parameter int          DATA_W       = 32,
  parameter int          NUM_WORDS    = 16,
  parameter logic [31:0] SYNC_WORD    = 32'hA5A5_5A5A,
  parameter int          HUNT_TIMEOUT = 1024
) (
  input logic             clk,
  input logic             rst_n,
  link_self_test_if.slave bus
);
  localparam int BC_W = $clog2(DATA_W);
  localparam int WC_W = $clog2(NUM_WORDS + 1);
  localparam int TC_W = $clog2(HUNT_TIMEOUT + 1);
  localparam logic [DATA_W-1:0] SYNC = SYNC_WORD[DATA_W-1:0];

  typedef enum logic [2:0] {IDLE, TX, HUNT, RX, DONE} state_t;

  state_t            state_q, state_d;
  logic [31:0]       lfsr_q, lfsr_d;
  logic [DATA_W-1:0] sh_q, sh_d;      // TX shift register, or RX/HUNT window
  logic [BC_W-1:0]   bit_q, bit_d;
  logic [TC_W-1:0]   cyc_q, cyc_d;
  logic [7:0]        err_q, err_d, err_nxt;
  logic [WC_W-1:0]   wc_q, wc_d;
  logic              to_q, to_d;
  logic              pass_q, pass_d;
  logic              src_q, src_d;    // f_layer captured at start
  logic              sync_q, sync_d;  // TX is still sending the sync word
  logic              fwd_q;
  logic [DATA_W-1:0] rx_word;

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
  endfunction

  assign rx_word = {sh_q[DATA_W-2:0], bus.data_in};

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lfsr_q  <= 32'h0000_0001;
      sh_q    <= '0;
      bit_q   <= '0;
      cyc_q   <= '0;
      err_q   <= '0;
      wc_q    <= '0;
      to_q    <= 1'b0;
      pass_q  <= 1'b0;
      src_q   <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      cyc_q   <= cyc_d;
      err_q   <= err_d;
      wc_q    <= wc_d;
      to_q    <= to_d;
      pass_q  <= pass_d;
      src_q   <= src_d;
      sync_q  <= sync_d;
    end
  end

  // One-cycle repeater for the bit stream towards the next layer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fwd_q <= 1'b0;
    else        fwd_q <= bus.data_in;
  end

  // Next-state logic: start handling, serialiser, sync hunt and word checker
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    cyc_d   = cyc_q;
    err_d   = err_q;
    wc_d    = wc_q;
    to_d    = to_q;
    pass_d  = pass_q;
    src_d   = src_q;
    sync_d  = sync_q;
    err_nxt = err_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          src_d  = bus.f_layer;
          lfsr_d = 32'h0000_0001;
          err_d  = '0;
          wc_d   = '0;
          to_d   = 1'b0;
          pass_d = 1'b0;
          bit_d  = '0;
          cyc_d  = '0;
          sync_d = 1'b1;
          if (bus.f_layer) begin
            sh_d    = SYNC;
            state_d = TX;
          end else begin
            sh_d    = '0;
            state_d = HUNT;
          end
        end
      end
      TX: begin
        bit_d = bit_q + BC_W'(1);
        sh_d  = {sh_q[DATA_W-2:0], 1'b0};
`ifdef LINK_ERR_INJECT_EN
        // Flip the word's LSB now; it reaches the wire as the word's last bit
        if (!sync_q && bit_q == '0 && bus.err_inject) sh_d[1] = ~sh_q[0];
`endif
        if (bit_q == BC_W'(DATA_W - 1)) begin
          bit_d  = '0;
          sync_d = 1'b0;
          if (!sync_q) wc_d = wc_q + WC_W'(1);
          if (!sync_q && wc_q == WC_W'(NUM_WORDS - 1)) begin
            state_d = DONE;
            pass_d  = 1'b1;
          end else begin
            sh_d   = lfsr_q[DATA_W-1:0];
            lfsr_d = lfsr_step(lfsr_q);
          end
        end
      end
      HUNT: begin
        sh_d  = rx_word;
        cyc_d = cyc_q + TC_W'(1);
        if (rx_word == SYNC) begin
          state_d = RX;
          bit_d   = '0;
        end else if (cyc_q == TC_W'(HUNT_TIMEOUT - 1)) begin
          state_d = DONE;
          to_d    = 1'b1;
          pass_d  = 1'b0;
        end
      end
      RX: begin
        sh_d  = rx_word;
        bit_d = bit_q + BC_W'(1);
        if (bit_q == BC_W'(DATA_W - 1)) begin
          bit_d = '0;
          if (rx_word != lfsr_q[DATA_W-1:0] && err_q != 8'hFF) err_nxt = err_q + 8'd1;
          err_d  = err_nxt;
          lfsr_d = lfsr_step(lfsr_q);
          wc_d   = wc_q + WC_W'(1);
          if (wc_q == WC_W'(NUM_WORDS - 1)) begin
            state_d = DONE;
            pass_d  = (err_nxt == 8'd0);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy      = (state_q == TX) || (state_q == HUNT) || (state_q == RX);
  assign bus.test_done = (state_q == DONE);
  assign bus.test_pass = pass_q;
  assign bus.timeout   = to_q;
  assign bus.err_cnt   = err_q;
  assign bus.word_cnt  = wc_q;
  assign bus.data_out  = (state_q == TX) ? sh_q[DATA_W-1] : (src_q ? 1'b0 : fwd_q);
endmodule

// File: tb/tb_link_self_test.sv
// tb/tb_link_self_test.sv - scoreboard bench: source and checker instances chained, directed scenarios
module tb_link_self_test;
  localparam int          DATA_W       = 8;
  localparam int          NUM_WORDS    = 4;
  localparam int          HUNT_TIMEOUT = 64;
  localparam logic [31:0] SYNC_WORD    = 32'h0000_00A5;

  typedef struct packed {
    logic       pass;
    logic       to;
    logic [7:0] err;
    logic [2:0] wc;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  link_self_test_if #(.NUM_WORDS(NUM_WORDS)) src_if ();
  link_self_test_if #(.NUM_WORDS(NUM_WORDS)) chk_if ();

  logic chk_din_sel = 1'b1;
  assign src_if.data_in = 1'b0;
  assign chk_if.data_in = chk_din_sel ? src_if.data_out : 1'b0;

  link_self_test #(.DATA_W(DATA_W), .NUM_WORDS(NUM_WORDS), .SYNC_WORD(SYNC_WORD),
                   .HUNT_TIMEOUT(HUNT_TIMEOUT)) u_src (.clk(clk), .rst_n(rst_n), .bus(src_if.slave));
  link_self_test #(.DATA_W(DATA_W), .NUM_WORDS(NUM_WORDS), .SYNC_WORD(SYNC_WORD),
                   .HUNT_TIMEOUT(HUNT_TIMEOUT)) u_chk (.clk(clk), .rst_n(rst_n), .bus(chk_if.slave));

  int   n_checks = 0;
  int   n_fail   = 0;
  res_t src_exp[$];
  res_t chk_exp[$];
  logic src_bits[$];
  res_t e_src, e_chk;
  logic exp_bit;
  logic src_done_prev = 1'b0, chk_done_prev = 1'b0;
  logic fwd_en = 1'b0, fwd_prev = 1'b0, fwd_prev_ok = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event not as expected", name);
  endtask

  task automatic cmp_res(input string who, input res_t act, input res_t exp);
    check({who, "_pass"},    32'(act.pass), 32'(exp.pass));
    check({who, "_timeout"}, 32'(act.to),   32'(exp.to));
    check({who, "_err_cnt"}, 32'(act.err),  32'(exp.err));
    check({who, "_word_cnt"}, 32'(act.wc),  32'(exp.wc));
  endtask

  // Monitor: results on test_done rise, source bit stream while busy, checker forwarding
  always @(negedge clk) begin
    if (src_if.test_done && !src_done_prev) begin
      if (src_exp.size() == 0) fail_now("src_unexpected_done");
      else begin
        e_src = src_exp.pop_front();
        cmp_res("src", {src_if.test_pass, src_if.timeout, src_if.err_cnt, src_if.word_cnt}, e_src);
      end
    end
    src_done_prev = src_if.test_done;
    if (chk_if.test_done && !chk_done_prev) begin
      if (chk_exp.size() == 0) fail_now("chk_unexpected_done");
      else begin
        e_chk = chk_exp.pop_front();
        cmp_res("chk", {chk_if.test_pass, chk_if.timeout, chk_if.err_cnt, chk_if.word_cnt}, e_chk);
      end
    end
    chk_done_prev = chk_if.test_done;
    if (src_if.busy) begin
      if (src_bits.size() == 0) fail_now("src_extra_bit");
      else begin
        exp_bit = src_bits.pop_front();
        check("src_bit", 32'(src_if.data_out), 32'(exp_bit));
      end
    end
    if (fwd_en && fwd_prev_ok) check("chk_forward", 32'(chk_if.data_out), 32'(fwd_prev));
    fwd_prev    = chk_if.data_in;
    fwd_prev_ok = fwd_en;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input bit s, input bit c);
    src_if.start = s;
    chk_if.start = c;
    tick(1);
    src_if.start = 1'b0;
    chk_if.start = 1'b0;
  endtask

  task automatic push_bits(input bit inj1, input bit inj3);
    logic [7:0] w [5];
    w[0] = 8'hA5;
    w[1] = 8'h01;
    w[2] = inj1 ? 8'h02 : 8'h03;
    w[3] = 8'h06;
    w[4] = inj3 ? 8'h0C : 8'h0D;
    for (int i = 0; i < 5; i++)
      for (int b = 7; b >= 0; b--) src_bits.push_back(w[i][b]);
  endtask

  task automatic wait_idle();
    int cnt = 0;
    while ((src_if.busy || chk_if.busy) && cnt < 500) begin
      tick(1);
      cnt++;
    end
    if (cnt >= 500) fail_now("wait_idle_timeout");
    tick(2);
  endtask

  task automatic check_all_zero(input string who, input logic busy, input logic done,
                                input logic pass, input logic to, input logic [7:0] err,
                                input logic [2:0] wc, input logic dout);
    check({who, "_busy0"},  32'(busy), 32'd0);
    check({who, "_done0"},  32'(done), 32'd0);
    check({who, "_pass0"},  32'(pass), 32'd0);
    check({who, "_to0"},    32'(to),   32'd0);
    check({who, "_err0"},   32'(err),  32'd0);
    check({who, "_wc0"},    32'(wc),   32'd0);
    check({who, "_dout0"},  32'(dout), 32'd0);
  endtask

  initial begin
    int cnt;
    src_if.f_layer = 1'b1;
    chk_if.f_layer = 1'b0;
    src_if.start   = 1'b0;
    chk_if.start   = 1'b0;
`ifdef LINK_ERR_INJECT_EN
    src_if.err_inject = 1'b0;
    chk_if.err_inject = 1'b0;
`endif
    #2 rst_n = 1'b0;
    #10;
    check_all_zero("rst_src", src_if.busy, src_if.test_done, src_if.test_pass, src_if.timeout,
                   src_if.err_cnt, src_if.word_cnt, src_if.data_out);
    check_all_zero("rst_chk", chk_if.busy, chk_if.test_done, chk_if.test_pass, chk_if.timeout,
                   chk_if.err_cnt, chk_if.word_cnt, chk_if.data_out);
    @(posedge clk);
    #1 rst_n = 1'b1;
    fwd_en = 1'b1;
    tick(2);

    // Source alone
    push_bits(0, 0);
    src_exp.push_back('{1'b1, 1'b0, 8'd0, 3'd4});
    pulse_start(1, 0);
    check("busy_after_start", 32'(src_if.busy), 32'd1);
    wait_idle();
    check("src_dout_idle_done", 32'(src_if.data_out), 32'd0);

    // Chain: checker hunts first, source from DONE
    pulse_start(0, 1);
    push_bits(0, 0);
    src_exp.push_back('{1'b1, 1'b0, 8'd0, 3'd4});
    chk_exp.push_back('{1'b1, 1'b0, 8'd0, 3'd4});
    pulse_start(1, 0);
    check("restart_src_wc_clear", 32'(src_if.word_cnt), 32'd0);
    check("restart_src_pass_clear", 32'(src_if.test_pass), 32'd0);
    wait_idle();

    // Re-run from DONE with start re-pulsed mid-test (must be ignored)
    pulse_start(0, 1);
    push_bits(0, 0);
    src_exp.push_back('{1'b1, 1'b0, 8'd0, 3'd4});
    chk_exp.push_back('{1'b1, 1'b0, 8'd0, 3'd4});
    pulse_start(1, 0);
    tick(12);
    src_if.f_layer = 1'b0;
    chk_if.f_layer = 1'b1;
    pulse_start(1, 1);
    src_if.f_layer = 1'b1;
    chk_if.f_layer = 1'b0;
    wait_idle();

`ifdef LINK_ERR_INJECT_EN
    // Corrupt payload words 1 and 3
    pulse_start(0, 1);
    push_bits(1, 1);
    src_exp.push_back('{1'b1, 1'b0, 8'd0, 3'd4});
    chk_exp.push_back('{1'b0, 1'b0, 8'd2, 3'd4});
    pulse_start(1, 0);
    for (int c = 0; c < 40; c++) begin
      src_if.err_inject = ((c / 8) == 2) || ((c / 8) == 4);
      tick(1);
    end
    src_if.err_inject = 1'b0;
    wait_idle();
`endif

    // Hunt timeout with a silent line
    chk_din_sel = 1'b0;
    chk_exp.push_back('{1'b0, 1'b1, 8'd0, 3'd0});
    pulse_start(0, 1);
    check("restart_chk_err_clear", 32'(chk_if.err_cnt), 32'd0);
    check("restart_chk_wc_clear", 32'(chk_if.word_cnt), 32'd0);
    cnt = 0;
    while (!chk_if.test_done && cnt < 200) begin
      tick(1);
      cnt++;
    end
    check("hunt_timeout_cycles", 32'(cnt), 32'd64);
    tick(2);
    chk_din_sel = 1'b1;
    tick(2);

    // Reset during RX word 2
    pulse_start(0, 1);
    push_bits(0, 0);
    pulse_start(1, 0);
    tick(28);
    check("chk_in_word2", 32'(chk_if.word_cnt), 32'd2);
    fwd_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    src_bits.delete();
    check_all_zero("mid_src", src_if.busy, src_if.test_done, src_if.test_pass, src_if.timeout,
                   src_if.err_cnt, src_if.word_cnt, src_if.data_out);
    check_all_zero("mid_chk", chk_if.busy, chk_if.test_done, chk_if.test_pass, chk_if.timeout,
                   chk_if.err_cnt, chk_if.word_cnt, chk_if.data_out);
    @(posedge clk);
    #1 rst_n = 1'b1;
    fwd_en = 1'b1;
    tick(2);
    pulse_start(0, 1);
    push_bits(0, 0);
    src_exp.push_back('{1'b1, 1'b0, 8'd0, 3'd4});
    chk_exp.push_back('{1'b1, 1'b0, 8'd0, 3'd4});
    pulse_start(1, 0);
    wait_idle();

    tick(3);
    check("src_exp_drained", 32'(src_exp.size()), 32'd0);
    check("chk_exp_drained", 32'(chk_exp.size()), 32'd0);
    check("src_bits_drained", 32'(src_bits.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
